// File: rtl/mult_if.sv
// Handshake and result bus for the iterative multiplier. The requester drives the operands
// and start; the multiplier returns the product halves together with busy and done.
interface mult_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, is_signed, A, B,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, is_signed, A, B,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_module.sv
// Shift-add 32x32 -> 64 multiplier for MULT/MULTU. It handles one partial product per clock.
// Signed operands are reduced to magnitudes, and the sign is applied when hi/lo load.
module mult_module #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_if.slave      bus,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;

  state_t state, state_next;

  // Handshake: start is accepted on any rising edge where busy is low (including the done
  // cycle). Inputs are otherwise ignored. done is a one-cycle pulse that always coincides
  // with a hi/lo update.
  logic               load_go;
  logic               step_go;
  logic               finish;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] product;

  // A most-negative operand negates to itself, and that value is still the correct
  // unsigned magnitude.
  assign a_abs = (bus.is_signed && bus.A[WIDTH-1]) ? (~bus.A + 1'b1) : bus.A;
  assign b_abs = (bus.is_signed && bus.B[WIDTH-1]) ? (~bus.B + 1'b1) : bus.B;

  // The multiplier sits in the low half of acc and is consumed LSB-first as the
  // partial sums shift in from the top. The carry of the add becomes the new MSB.
  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_step = {sum, acc[WIDTH-1:1]};
  assign product  = neg ? (~acc_step + 1'b1) : acc_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_go    = 1'b0;
    step_go    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load_go    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step_go = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (load_go) begin
        mcand <= a_abs;
        acc   <= {{WIDTH{1'b0}}, b_abs};
        neg   <= bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
        cnt   <= '0;
      end else if (step_go) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        hi_q <= product[2*WIDTH-1:WIDTH];
        lo_q <= product[WIDTH-1:0];
      end
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state == RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_mult_module.sv
// Bench for mult_module: directed corner cases plus randomized operands, checked against
// an arithmetic reference product through an expected-value queue.
module tb_mult_module;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  mult_if #(.WIDTH(W)) bus ();

  mult_module #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    longint la, lb;
    if (s) begin
      la = $signed(a);
      lb = $signed(b);
      return la * lb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Drivers
  // Call while busy is low, #1 after an edge. Returns #1 after the done edge, so a
  // following call restarts in the done cycle. A nonzero poke re-pulses start with new
  // operands on that run cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int poke);
    logic [63:0] exp;
    logic [63:0] prev_hl;
    int          lat;
    logic        held;
    bus.start     = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.is_signed = s;
    exp_q.push_back(ref_prod(a, b, s));
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.A         = $urandom;
    bus.B         = $urandom;
    bus.is_signed = 1'($urandom_range(0, 1));
    check("busy_after_start", 64'(bus.busy), 64'd1);
    check("done_low_after_start", 64'(bus.done), 64'd0);
    lat     = 0;
    held    = 1'b1;
    prev_hl = {bus.hi, bus.lo};
    for (int n = 1; n <= 40; n++) begin
      if (n == poke) begin
        bus.start = 1'b1;
        bus.A     = 32'h0000_1234;
        bus.B     = 32'h0000_5678;
      end
      if (n == poke + 1) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      if ({bus.hi, bus.lo} !== prev_hl) held = 1'b0;
    end
    bus.start = 1'b0;
    check("latency", 64'(lat), 64'd32);
    check("hold_during_run", 64'(held), 64'd1);
    check("busy_at_done", 64'(bus.busy), 64'd0);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("product", {bus.hi, bus.lo}, exp);
    end else begin
      check("exp_q_empty", 64'(exp_q.size()), 64'd1);
    end
  endtask

  task automatic idle_check();
    logic [63:0] hl;
    hl = {bus.hi, bus.lo};
    @(posedge clk); #1;
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_hold", {bus.hi, bus.lo}, hl);
  endtask

  initial begin
    logic saw_done;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.A         = '0;
    bus.B         = '0;

    #1;
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(32'd10, 32'd10, 1'b0, 0);
    idle_check();

    run_op(32'd5, 32'd3, 1'b0, 0);
    run_op(32'd0, 32'd10, 1'b0, 0);
    run_op(32'd4, 32'd5, 1'b0, 0);
    idle_check();

    run_op(32'd5, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'd5, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    idle_check();

    // A second start during the run must be ignored.
    run_op(32'd7, 32'd9, 1'b0, 10);
    idle_check();

    // Asynchronous reset mid-run, applied between clock edges.
    bus.start = 1'b1;
    bus.A     = 32'd123;
    bus.B     = 32'd456;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_hi", 64'(bus.hi), 64'd0);
    check("async_reset_lo", 64'(bus.lo), 64'd0);
    check("async_reset_busy", 64'(bus.busy), 64'd0);
    check("async_reset_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("no_done_after_reset", 64'(saw_done), 64'd0);
    run_op(32'd123, 32'd456, 1'b0, 0);
    idle_check();

    for (int i = 0; i < 40; i++) begin
      run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_module.md
Name: mult_module

Overview:
- Iterative 32x32 -> 64-bit multiplier for the MIPS processor's MULT/MULTU path.
- Takes two 32-bit operands plus a signed/unsigned select.
- Produces a 64-bit product split into hi (upper 32 bits) and lo (lower 32 bits), which feed the HI/LO registers.
- Uses a shift-add datapath: one partial-product step per clock, with a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width. The product is 2*WIDTH; hi and lo are WIDTH each.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request a multiply; sampled only when busy=0
- is_signed  input  1  1 = two's-complement multiply (MULT), 0 = unsigned (MULTU); sampled with start
- A  input  WIDTH  multiplicand; sampled with start
- B  input  WIDTH  multiplier; sampled with start
- hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
- lo  output  WIDTH  product bits [WIDTH-1:0]
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse when hi/lo take a new result

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; hi=0, lo=0, busy=0, done=0.
  - Internal accumulator, operand registers and counter cleared.
  - A pending operation is discarded.
- States:
  - IDLE: if start=1 at a rising edge E0, latch A, B, is_signed; go to RUN; counter=0; busy=1 after E0.
  - RUN: one iteration per edge, at edges E1..E32 (WIDTH iterations).
    - If multiplier LSB=1, add the multiplicand magnitude to the upper half of the 2*WIDTH accumulator (keep carry).
    - Then shift right by 1.
  - At E32: load the final product into hi/lo, busy=0, done=1 for exactly one cycle, return to IDLE.
- Latency: result visible on hi/lo and done=1 in the cycle following the 32nd edge after the start-sampling edge, i.e. 32 clocks; throughput one result per 33 cycles minimum.
- Back-to-back: start may be asserted in the cycle done=1 (busy is already 0) and is accepted.
- Start while busy=1: ignored; inputs during RUN have no effect on the operation in progress.
- Signed mode:
  - Operate on magnitudes |A| and |B|.
  - Negate the 64-bit result (two's complement) if sign(A) XOR sign(B).
  - The negation is folded into the final load at E32 with no extra cycle.
  - |0x80000000| = 0x80000000 treated as a 32-bit unsigned magnitude; the result must be exact for all inputs including the most-negative value.
- Unsigned mode: plain 64-bit unsigned product, no sign handling.
- hi/lo hold the last result until the next completion or reset; they do not change during RUN.
- The product is always exact; there is no overflow or truncation.
- done is never asserted without a corresponding hi/lo update.

Test Plan:
- After reset: hi=0, lo=0, busy=0, done=0. Then unsigned A=10, B=10 -> after 32 clocks done pulses, hi=0x00000000, lo=0x00000064.
- Unsigned sequence A=5,B=3 / A=0,B=10 / A=4,B=5, back-to-back with start re-asserted on each done cycle:
  - lo=0x0000000F, 0x00000000, 0x00000014 respectively; hi=0 each time.
  - done high exactly one cycle per operation.
- A=5, B=0xFFFFFFFF:
  - unsigned -> hi=0x00000004, lo=0xFFFFFFFB.
  - signed -> hi=0xFFFFFFFF, lo=0xFFFFFFFB.
- Signed corner: A=B=0x80000000 -> hi=0x40000000, lo=0x00000000. Signed A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0, lo=1.
- Start with A=7,B=9, then change A/B and pulse start at cycle 10 while busy -> second start ignored; result lo=0x3F, hi=0.
- Assert reset asynchronously mid-RUN (cycle 15) -> hi/lo/busy/done go to 0 immediately with no clock edge needed; no done pulse follows. A new start after reset release completes normally.
